// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display scanner.
// Holds the digit count, the blank segment pattern and the active-low
// seven-segment decode table (bit order {dp,g,f,e,d,c,b,a}, dp always off).
package hex_display_pkg;

  localparam int unsigned DIGITS = 8;
  localparam int unsigned IDX_W  = 3;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;

  // Packed so that SEG_TABLE[n] is the pattern for nibble value n.
  localparam logic [15:0][7:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  // Active-low enable for a single digit.
  function automatic logic [DIGITS-1:0] digit_enable(input logic [IDX_W-1:0] idx);
    logic [DIGITS-1:0] one_hot;
    one_hot = '0;
    one_hot[idx] = 1'b1;
    return ~one_hot;
  endfunction

endpackage

// File: rtl/hex_display_scan_hex_to_seg7.sv
// Combinational nibble to seven-segment decoder.
// Ports:
//   nibble - 4-bit hex value
//   seg    - active-low segment pattern {dp,g,f,e,d,c,b,a}, dp off
module hex_to_seg7 (
  input  logic [3:0] nibble,
  output logic [7:0] seg
);
  import hex_display_pkg::*;

  always_comb begin
    seg = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/hex_display_scan.sv
// Eight-digit multiplexed hex display driver for a common-anode module.
// A frame value is latched once per scan so every frame is drawn from one
// consistent word; optional leading-zero blanking keeps digit 0 always lit.
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   data_in    - 32-bit value, nibble k shown on digit k (digit 0 rightmost)
//   blank_lz   - 1 blanks leading zero digits
//   led_en     - active-low digit enables, one low bit or all high
//   seg        - active-low segments {dp,g,f,e,d,c,b,a}
//   frame_tick - one-cycle pulse after a new frame value is captured
module hex_display_scan #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic        blank_lz,
  output logic [7:0]  led_en,
  output logic [7:0]  seg,
  output logic        frame_tick
);
  import hex_display_pkg::*;

  // SCAN_DIV may be as large as 2^24, so its terminal count fits in 24 bits.
  localparam logic [23:0] DIV_LAST = 24'(SCAN_DIV - 1);

  logic [23:0]      div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      frame_q, frame_d;
  logic             lz_q, lz_d;
  logic             tick;
  logic             capture;

  logic [3:0]  nibble;
  logic [7:0]  seg_raw;
  logic [31:0] frame_upper;
  logic        blanked;
  logic [7:0]  led_en_d, seg_d;

  // Scan timing and frame capture.
  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    capture   = tick && (idx_q == IDX_W'(DIGITS - 1));
    div_cnt_d = tick ? 24'd0 : div_cnt_q + 24'd1;
    idx_d     = tick ? idx_q + IDX_W'(1) : idx_q;
    frame_d   = capture ? data_in : frame_q;
    lz_d      = capture ? blank_lz : lz_q;
  end

  // Digit selection and blanking work only on captured state, so there is
  // no path from data_in to the outputs.
  always_comb begin
    nibble      = frame_q[{idx_q, 2'b00} +: 4];
    frame_upper = frame_q >> {idx_q, 2'b00};
    blanked     = lz_q && (idx_q != '0) && (frame_upper == 32'd0);
    led_en_d    = blanked ? SEG_BLANK : digit_enable(idx_q);
    seg_d       = blanked ? SEG_BLANK : seg_raw;
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .seg    (seg_raw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= 24'd0;
      idx_q      <= '0;
      frame_q    <= 32'd0;
      lz_q       <= 1'b0;
      led_en     <= 8'hFF;
      seg        <= SEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      lz_q       <= lz_d;
      led_en     <= led_en_d;
      seg        <= seg_d;
      frame_tick <= capture;
    end
  end

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan with SCAN_DIV=4 and SCAN_DIV=1 instances.
module tb_hex_display_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_in = 32'd0;
  logic        blank_lz = 1'b0;
  logic [7:0]  led4, seg4, led1, seg1;
  logic        ft4, ft1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hex_display_scan #(.SCAN_DIV(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .blank_lz   (blank_lz),
    .led_en     (led4),
    .seg        (seg4),
    .frame_tick (ft4)
  );

  hex_display_scan #(.SCAN_DIV(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .blank_lz   (blank_lz),
    .led_en     (led1),
    .seg        (seg1),
    .frame_tick (ft1)
  );

  // Hand-computed expectations.
  logic [7:0] led_hot   [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0] seg_abcd  [8] = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
  logic [7:0] led_f0    [8] = '{8'hFE, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] seg_f0    [8] = '{8'hC0, 8'h8E, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] led_zero  [8] = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] seg_zero  [8] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %02h want %02h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (ft4 !== 1'b1 && n < 40);
    total++;
    assert (ft4 === 1'b1) else begin
      bad++;
      $error("FAIL %s: frame_tick got %0b want 1 within 40 cycles", tag, ft4);
    end
  endtask

  initial begin
    int d;

    // Reset state while held in reset.
    data_in  = 32'h1234ABCD;
    blank_lz = 1'b0;
    rst_n    = 1'b0;
    #12;
    chk("rst_led4", led4, 8'hFF);
    chk("rst_seg4", seg4, 8'hFF);
    chk("rst_ft4", {7'd0, ft4}, 8'h00);
    chk("rst_led1", led1, 8'hFF);
    chk("rst_seg1", seg1, 8'hFF);
    chk("rst_ft1", {7'd0, ft1}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero frame then 1234ABCD frame; SCAN_DIV=1 rotates every cycle.
    for (int e = 1; e <= 64; e++) begin
      step();
      d = ((e - 1) / 4) % 8;
      chk($sformatf("led4_e%0d", e), led4, led_hot[d]);
      chk($sformatf("seg4_e%0d", e), seg4, (e <= 32) ? 8'hC0 : seg_abcd[d]);
      chk($sformatf("ft4_e%0d", e), {7'd0, ft4}, {7'd0, (e % 32) == 0});
      d = (e - 1) % 8;
      chk($sformatf("led1_e%0d", e), led1, led_hot[d]);
      chk($sformatf("seg1_e%0d", e), seg1, (e <= 8) ? 8'hC0 : seg_abcd[d]);
      chk($sformatf("ft1_e%0d", e), {7'd0, ft1}, {7'd0, (e % 8) == 0});
    end

    // Leading-zero blanking on 0x000000F0.
    blank_lz = 1'b1;
    data_in  = 32'h000000F0;
    wait_frame("wait_f0");
    for (int k = 1; k <= 32; k++) begin
      step();
      d = (k - 1) / 4;
      chk($sformatf("lz_led_k%0d", k), led4, led_f0[d]);
      chk($sformatf("lz_seg_k%0d", k), seg4, seg_f0[d]);
    end

    // Value zero with blanking: only digit 0 lit.
    data_in = 32'd0;
    wait_frame("wait_zero");
    for (int k = 1; k <= 32; k++) begin
      step();
      d = (k - 1) / 4;
      chk($sformatf("z_led_k%0d", k), led4, led_zero[d]);
      chk($sformatf("z_seg_k%0d", k), seg4, seg_zero[d]);
    end

    // Tear check: change data mid-frame.
    blank_lz = 1'b0;
    data_in  = 32'h11111111;
    wait_frame("wait_ones");
    for (int k = 1; k <= 32; k++) begin
      if (k == 13) data_in = 32'h22222222;
      step();
      d = (k - 1) / 4;
      chk($sformatf("t1_led_k%0d", k), led4, led_hot[d]);
      chk($sformatf("t1_seg_k%0d", k), seg4, 8'hF9);
      chk($sformatf("t1_ft_k%0d", k), {7'd0, ft4}, {7'd0, k == 32});
    end
    for (int k = 1; k <= 32; k++) begin
      step();
      d = (k - 1) / 4;
      chk($sformatf("t2_led_k%0d", k), led4, led_hot[d]);
      chk($sformatf("t2_seg_k%0d", k), seg4, 8'hA4);
      chk($sformatf("t2_ft_k%0d", k), {7'd0, ft4}, {7'd0, k == 32});
    end

    // Reset during digit 5, between clock edges.
    for (int k = 1; k <= 21; k++) step();
    chk("pre_rst_led4", led4, 8'hDF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_led4", led4, 8'hFF);
    chk("async_seg4", seg4, 8'hFF);
    chk("async_ft4", {7'd0, ft4}, 8'h00);
    chk("async_led1", led1, 8'hFF);
    chk("async_seg1", seg1, 8'hFF);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("rel_led4_k%0d", k), led4, (k <= 4) ? 8'hFE : 8'hFD);
      chk($sformatf("rel_seg4_k%0d", k), seg4, 8'hC0);
      chk($sformatf("rel_ft4_k%0d", k), {7'd0, ft4}, 8'h00);
      chk($sformatf("rel_led1_k%0d", k), led1, led_hot[k - 1]);
      chk($sformatf("rel_seg1_k%0d", k), seg1, 8'hC0);
    end

    // Random-data invariants.
    for (int n = 0; n < 800; n++) begin
      data_in  = $urandom;
      blank_lz = 1'($urandom_range(0, 1));
      step();
      chk($sformatf("onehot4_n%0d", n), {7'd0, $countones(~led4) <= 1}, 8'h01);
      chk($sformatf("onehot1_n%0d", n), {7'd0, $countones(~led1) <= 1}, 8'h01);
      if (led4 == 8'hFF) chk($sformatf("blank4_n%0d", n), seg4, 8'hFF);
      else chk($sformatf("dp4_n%0d", n), {7'd0, seg4[7]}, 8'h01);
      if (led1 == 8'hFF) chk($sformatf("blank1_n%0d", n), seg1, 8'hFF);
      else chk($sformatf("dp1_n%0d", n), {7'd0, seg1[7]}, 8'h01);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
